// File: rtl/operand_fetch_if.sv
// Handshake and writeback bundle between the decoder, the operand_fetch
// issue stage and the execute stage.
interface operand_fetch_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [2:0]        out_alu_op;
  logic [ADDR_W-1:0] out_rd;

  // Issue stage side
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    output in_ready,
    input  wb_en, wb_addr, wb_data,
    output out_valid, out_a, out_b, out_alu_op, out_rd,
    input  out_ready
  );

  // Decoder / execute side
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    input  in_ready,
    output wb_en, wb_addr, wb_data,
    input  out_valid, out_a, out_b, out_alu_op, out_rd,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// Issue stage ahead of the 19-bit ALU: register file, busy scoreboard,
// same-cycle writeback bypass and a single registered operand bundle.
module operand_fetch #(
  parameter int DATA_W  = 19,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave io_bus
);

  localparam logic [REG_CNT-1:0] NOT_R0 = {{(REG_CNT-1){1'b1}}, 1'b0};

  logic [DATA_W-1:0]  r_regs [REG_CNT];
  logic [REG_CNT-1:0] r_busy;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_a;
  logic [DATA_W-1:0]  r_out_b;
  logic [2:0]         r_out_op;
  logic [ADDR_W-1:0]  r_out_rd;

  logic [REG_CNT-1:0] w_wb_hit;
  logic [REG_CNT-1:0] w_eff_busy;
  logic [REG_CNT-1:0] w_set;
  logic [REG_CNT-1:0] w_busy_nxt;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic               w_hazard;
  logic               w_space;
  logic               w_in_ready;
  logic               w_accept;

  // One-hot of the register being written back this cycle (r0 excluded)
  always_comb begin
    w_wb_hit = '0;
    if (io_bus.wb_en) w_wb_hit[io_bus.wb_addr] = 1'b1;
    w_wb_hit = w_wb_hit & NOT_R0;
  end

  // A same-cycle writeback resolves the hazard on its register
  assign w_eff_busy = r_busy & ~w_wb_hit;

  // Operand a: r0 is zero, then writeback bypass, then register file
  always_comb begin
    w_a = '0;
    if (io_bus.in_rs1 != '0) begin
      if (io_bus.wb_en && (io_bus.wb_addr == io_bus.in_rs1)) w_a = io_bus.wb_data;
      else                                                   w_a = r_regs[io_bus.in_rs1];
    end
  end

  // Operand b: immediate overrides rs2 entirely
  always_comb begin
    w_b = '0;
    if (io_bus.in_use_imm) begin
      w_b = io_bus.in_imm;
    end else if (io_bus.in_rs2 != '0) begin
      if (io_bus.wb_en && (io_bus.wb_addr == io_bus.in_rs2)) w_b = io_bus.wb_data;
      else                                                   w_b = r_regs[io_bus.in_rs2];
    end
  end

  // RAW on rs1/rs2 and WAW on rd all stall through the same busy bits
  assign w_hazard   = io_bus.in_valid &&
                      (w_eff_busy[io_bus.in_rs1] ||
                       (!io_bus.in_use_imm && w_eff_busy[io_bus.in_rs2]) ||
                       w_eff_busy[io_bus.in_rd]);
  assign w_space    = !r_out_valid || io_bus.out_ready;
  assign w_in_ready = w_space && !w_hazard;
  assign w_accept   = io_bus.in_valid && w_in_ready;

  // Scoreboard next state: clear on writeback, then set on accept (set wins)
  always_comb begin
    w_set = '0;
    if (w_accept) w_set[io_bus.in_rd] = 1'b1;
    w_busy_nxt = ((r_busy & ~w_wb_hit) | w_set) & NOT_R0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Register file; r0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else if (io_bus.wb_en && (io_bus.wb_addr != '0)) begin
      r_regs[io_bus.wb_addr] <= io_bus.wb_data;
    end
  end

  // Output bundle: load on accept, drain on out_ready, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_op    <= '0;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_a;
      r_out_b     <= w_b;
      r_out_op    <= io_bus.in_op;
      r_out_rd    <= io_bus.in_rd;
    end else if (io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_a      = r_out_a;
  assign io_bus.out_b      = r_out_b;
  assign io_bus.out_alu_op = r_out_op;
  assign io_bus.out_rd     = r_out_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with hand-computed expectations.
module tb_operand_fetch;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  operand_fetch_if #(.DATA_W(19), .ADDR_W(4)) bus ();

  operand_fetch #(.DATA_W(19), .REG_CNT(16), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic use_imm, input logic [18:0] imm);
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
  endtask

  task automatic set_wb(input logic en, input logic [3:0] addr, input logic [18:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [18:0] a,
                         input logic [18:0] b, input logic [2:0] op, input logic [3:0] rd);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".a"},     32'(bus.out_a),     32'(a));
    chk({tag, ".b"},     32'(bus.out_b),     32'(b));
    chk({tag, ".op"},    32'(bus.out_alu_op), 32'(op));
    chk({tag, ".rd"},    32'(bus.out_rd),    32'(rd));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    bus.out_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("idle_ready", 32'(bus.in_ready), 32'd1);

    // r3 = 5 through writeback
    set_wb(1, 4'd3, 19'h00005);
    tick();
    set_wb(0, 0, 0);

    // ADD r4 = r3, r0
    set_in(1, 3'd0, 4'd4, 4'd3, 4'd0, 0, 0);
    #1 chk("add_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_out("add", 1, 19'h00005, 19'h0, 3'd0, 4'd4);

    // RAW on r4: stalls until the writeback of r4
    set_in(1, 3'd1, 4'd7, 4'd4, 4'd0, 0, 0);
    #1 chk("raw_stall0", 32'(bus.in_ready), 32'd0);
    tick();
    chk("raw_drain", 32'(bus.out_valid), 32'd0);
    chk("raw_stall1", 32'(bus.in_ready), 32'd0);
    set_wb(1, 4'd4, 19'h7FFFF);
    #1 chk("raw_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_wb(0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_out("raw", 1, 19'h7FFFF, 19'h0, 3'd1, 4'd7);

    // Make r5 busy, then immediate with r0 and busy rs2 must not stall
    set_in(1, 3'd0, 4'd5, 4'd0, 4'd0, 0, 0);
    tick();
    set_in(1, 3'd3, 4'd8, 4'd0, 4'd5, 1, 19'h12345);
    #1 chk("imm_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk_out("imm", 1, 19'h0, 19'h12345, 3'd3, 4'd8);
    set_in(1, 3'd0, 4'd9, 4'd0, 4'd5, 0, 0);
    #1 chk("rs2_stall", 32'(bus.in_ready), 32'd0);

    // Backpressure with a second instruction pending
    bus.out_ready = 1'b0;
    set_in(1, 3'd2, 4'd10, 4'd3, 4'd0, 1, 19'h00ABC);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk_out("bp_hold", 1, 19'h0, 19'h12345, 3'd3, 4'd8);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_out("bp_second", 1, 19'h00005, 19'h00ABC, 3'd2, 4'd10);
    tick();
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // WAW with same-cycle writeback: set wins
    set_in(1, 3'd4, 4'd6, 4'd0, 4'd0, 1, 19'h00001);
    tick();
    set_in(1, 3'd5, 4'd6, 4'd0, 4'd0, 1, 19'h00002);
    set_wb(1, 4'd6, 19'h11111);
    #1 chk("waw_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_wb(0, 0, 0);
    chk_out("waw", 1, 19'h0, 19'h00002, 3'd5, 4'd6);
    set_in(1, 3'd0, 4'd11, 4'd6, 4'd0, 1, 0);
    #1 chk("waw_still_busy", 32'(bus.in_ready), 32'd0);

    // Bypass of r6 writeback into operand a
    set_wb(1, 4'd6, 19'h22222);
    #1 chk("byp_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_wb(0, 0, 0);
    chk_out("bypass", 1, 19'h22222, 19'h0, 3'd0, 4'd11);

    // r6 now read from the register file, rd=0 never marks busy
    set_in(1, 3'd6, 4'd0, 4'd6, 4'd3, 0, 0);
    tick();
    chk_out("regread", 1, 19'h22222, 19'h00005, 3'd6, 4'd0);

    // Writeback to r0 is ignored and not bypassed
    set_in(1, 3'd0, 4'd0, 4'd0, 4'd0, 0, 0);
    set_wb(1, 4'd0, 19'h00555);
    #1 chk("r0_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_wb(0, 0, 0);
    chk_out("r0", 1, 19'h0, 19'h0, 3'd0, 4'd0);

    // r7 still busy before reset; hold a bundle under backpressure
    set_in(1, 3'd1, 4'd12, 4'd0, 4'd0, 1, 19'h00077);
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    set_in(1, 3'd0, 4'd1, 4'd7, 4'd0, 1, 0);
    bus.out_ready = 1'b1;
    #1 chk("pre_rst_r7_busy", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b0;

    // Async reset between edges
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_busy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1, 3'd2, 4'd1, 4'd3, 4'd7, 0, 0);
    #1 chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_out("post_rst", 1, 19'h0, 19'h0, 3'd2, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
